// File: rtl/if_fetch_queue_if.sv
// Bundles the fetch queue's instruction-memory port and decode handshake.
// The master side is the fetch queue; the slave side is memory plus decode.
interface if_fetch_queue_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] mem_addr;
  logic              mem_read;
  logic [1:0]        mem_byte_enable;
  logic              mem_resp;
  logic [WORD_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_inst;
  logic              out_pred_taken;

  modport master (
    output mem_addr, mem_read, mem_byte_enable,
    input  mem_resp, mem_rdata,
    output out_valid, out_pc, out_inst, out_pred_taken,
    input  out_ready
  );

  modport slave (
    input  mem_addr, mem_read, mem_byte_enable,
    output mem_resp, mem_rdata,
    input  out_valid, out_pc, out_inst, out_pred_taken,
    output out_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage with a QDEPTH-entry prefetch queue between instruction memory and decode.
// Define FETCH_PREDECODE_EN to predict backward BR words taken at fetch time.
module if_fetch_queue #(
  parameter int              WORD_W   = 16,
  parameter int              QDEPTH   = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [WORD_W-1:0]            redirect_pc,
  if_fetch_queue_if.master             bus,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] fetch_pc, fetch_pc_next;
  logic [WORD_W-1:0] addr_q, addr_next;
  logic [CW-1:0]     count, count_next;
  logic [PW-1:0]     head, tail;

  logic [WORD_W-1:0] pc_q   [QDEPTH];
  logic [WORD_W-1:0] inst_q [QDEPTH];
  logic [QDEPTH-1:0] pred_q;

  logic              push, pop, room;
  logic              pred_hit;
  logic [WORD_W-1:0] seq_pc, push_next_pc;

  assign seq_pc = fetch_pc + WORD_W'(2);

`ifdef FETCH_PREDECODE_EN
  // Backward BR with all condition bits set is treated as an always-taken loop branch.
  logic [WORD_W-1:0] br_target;
  assign pred_hit  = (bus.mem_rdata[15:12] == 4'b0000) &&
                     (bus.mem_rdata[11:9] == 3'b111) && bus.mem_rdata[8];
  assign br_target = seq_pc + {{(WORD_W-10){bus.mem_rdata[8]}}, bus.mem_rdata[8:0], 1'b0};
  assign push_next_pc = pred_hit ? br_target : seq_pc;
`else
  assign pred_hit     = 1'b0;
  assign push_next_pc = seq_pc;
`endif

  // Next-state logic; a redirect overrides push, pop and any normal transition.
  always_comb begin
    push          = (state == FETCH) && bus.mem_resp && !redirect_valid;
    pop           = bus.out_valid && bus.out_ready && !redirect_valid;
    count_next    = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    room          = count_next < CW'(QDEPTH);
    state_next    = state;
    fetch_pc_next = fetch_pc;
    addr_next     = addr_q;

    unique case (state)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          addr_next     = redirect_pc;
          state_next    = FETCH;
        end else if (room) begin
          addr_next  = fetch_pc;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          fetch_pc_next = redirect_pc;
          if (bus.mem_resp) begin
            addr_next  = redirect_pc;
            state_next = FETCH;
          end else begin
            state_next = DISCARD;
          end
        end else if (bus.mem_resp) begin
          fetch_pc_next = push_next_pc;
          if (room) begin
            addr_next  = push_next_pc;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DISCARD: begin
        // The stale read must finish at its original address before refetching.
        if (redirect_valid) fetch_pc_next = redirect_pc;
        if (bus.mem_resp) begin
          addr_next  = fetch_pc_next;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      pred_q   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      addr_q   <= addr_next;
      count    <= count_next;
      if (redirect_valid) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) begin
          pc_q[tail]   <= fetch_pc;
          inst_q[tail] <= bus.mem_rdata;
          pred_q[tail] <= pred_hit;
          tail         <= tail + PW'(1);
        end
        if (pop) head <= head + PW'(1);
      end
    end
  end

  assign bus.mem_read        = (state == FETCH) || (state == DISCARD);
  assign bus.mem_addr        = addr_q;
  assign bus.mem_byte_enable = 2'b11;
  assign bus.out_valid       = (count != '0);
  assign bus.out_pc          = pc_q[head];
  assign bus.out_inst        = inst_q[head];
  assign bus.out_pred_taken  = pred_q[head];
  assign q_count             = count;

endmodule
